misr_compactor: RTL and testbench
=================================

# misr_compactor

Parametrised multiple-input signature register (MISR) with a built-in run controller, for BIST response compaction. It replaces the fixed 16-bit/10-input compactor in the BIST-per-scan path with configurable signature width, input width, feedback polynomial, seed and golden value. It adds a pattern counter that ends the run automatically, a registered pass/fail verdict, and a serial signature unload port for the scan/debug chain.

## Interface
- SIG_W, 16: signature width; must be ≥ IN_W and ≥ 2.
- IN_W, 10: parallel response input width.
- POLY, 16'h1021: feedback taps, SIG_W bits; bit i set means sig[SIG_W-1] is XORed into bit i.
- SEED, 0: value loaded on reset and on run start.
- GOLDEN, 16'h0000: expected final signature, SIG_W bits.
- CNT_W, 16: pattern counter width.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- data_valid  in  1  compaction beat qualifier.
- data_in  in  IN_W  circuit response vector.
- pattern_count  in  CNT_W  number of beats in the run; captured when start is accepted.
- unload  in  1  request to shift the signature out serially; honoured only in DONE.
- signature  out  SIG_W  current MISR contents.
- busy  out  1  high in COMPACT and UNLOAD.
- done  out  1  high in DONE.
- pass_nfail  out  1  in DONE/UNLOAD: (signature == GOLDEN); 0 otherwise.
- sig_serial_out  out  1  serial signature bit, MSB first.
- sig_serial_valid  out  1  qualifies sig_serial_out.

## Operation
- States: IDLE, COMPACT, DONE, UNLOAD.
- Reset values:
  - state = IDLE, signature = SEED, beat counter = 0.
  - busy, done, pass_nfail, sig_serial_out and sig_serial_valid are all 0.
- IDLE or DONE with start:
  - signature ← SEED, counter ← 0, pattern_count latched.
  - If latched count = 0, go to DONE; otherwise go to COMPACT.
- COMPACT:
  - On each data_valid cycle: signature ← {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extend(data_in). Counter increments.
  - The beat that makes counter = latched count moves the block to DONE on the same edge.
  - With data_valid low, signature and counter hold.
  - start and unload are ignored.
- DONE:
  - signature holds.
  - unload copies signature into a shadow shift register, sets a bit counter to SIG_W, and moves to UNLOAD.
  - If start and unload arrive together, start wins.
- UNLOAD:
  - Each cycle: sig_serial_valid = 1 and sig_serial_out = shadow MSB; then shadow shifts left and the bit counter decrements.
  - After SIG_W bits, return to DONE.
  - signature and pass_nfail stay stable throughout; start, unload and data_valid are ignored.
- Arithmetic:
  - The counter compares against the latched count at full CNT_W width.
  - pattern_count = 2^CNT_W − 1 is legal.
  - The counter never wraps within a run.
- Reset asserted in any state aborts immediately to the reset values; no partial unload completes.

## Timing
- start sampled at edge t:
  - signature = SEED and busy = 1 from t+1 when the count is non-zero.
  - When the count is 0: done = 1 from t+1, busy stays 0.
- Beat at edge t: the updated signature is visible from t+1.
- Final beat at edge t: done = 1 and pass_nfail valid from t+1. pass_nfail is derived from the registered signature and state, with no extra latency.
- unload at edge t: serial bits appear on cycles t+1 … t+SIG_W; done = 1 again from t+SIG_W+1.
- Throughput: one beat per clock; gaps are allowed.

## Test plan
- Defaults, start with pattern_count = 2, beats data_in = 10'h001 then 10'h000 → signature 16'h0001 then 16'h0002; done high the cycle after the second beat.
- Polynomial feedback: build a run whose pre-beat signature is 16'h8000, then apply one beat with data_in = 0 → signature 16'h1021.
- data_valid toggled 1,0,0,1 with pattern_count = 2 → no update or count on the low cycles; DONE only after the second valid beat.
- pattern_count = 0 → done at t+1 with signature = SEED; pass_nfail = 1 when GOLDEN = SEED, else 0.
- signature 16'hA5C3 in DONE, pulse unload → serial stream 1010_0101_1100_0011 on 16 consecutive valid cycles; signature unchanged; start held during UNLOAD ignored.
- Assert reset mid-COMPACT and mid-UNLOAD → outputs immediately at reset values; state IDLE; next start runs from SEED correctly.

Source files
------------

// File: rtl/misr_compactor.sv
// misr_compactor
// Multiple-input signature register with run controller for BIST response
// compaction. A run starts on `start`, absorbs `pattern_count` qualified beats,
// then holds the signature with a registered-path pass/fail verdict. From DONE
// the signature can be shifted out serially, MSB first.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-high reset
//   start            run request, honoured in IDLE or DONE
//   data_valid       qualifies data_in as a compaction beat
//   data_in          circuit response vector (IN_W bits)
//   pattern_count    beats in the run, captured when start is accepted
//   unload           serial unload request, honoured in DONE
//   signature        current MISR contents
//   busy             high in COMPACT and UNLOAD
//   done             high in DONE
//   pass_nfail       signature == GOLDEN while in DONE/UNLOAD
//   sig_serial_out   serial signature bit, MSB first
//   sig_serial_valid qualifies sig_serial_out
//
// state   | meaning
// IDLE    | after reset, waiting for start
// COMPACT | absorbing beats until the latched count is reached
// DONE    | signature final, verdict valid
// UNLOAD  | shifting the shadow copy out serially

module misr_compactor #(
  parameter int               SIG_W  = 16,
  parameter int               IN_W   = 10,
  parameter logic [SIG_W-1:0] POLY   = 16'h1021,
  parameter logic [SIG_W-1:0] SEED   = '0,
  parameter logic [SIG_W-1:0] GOLDEN = 16'h0000,
  parameter int               CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             data_valid,
  input  logic [IN_W-1:0]  data_in,
  input  logic [CNT_W-1:0] pattern_count,
  input  logic             unload,
  output logic [SIG_W-1:0] signature,
  output logic             busy,
  output logic             done,
  output logic             pass_nfail,
  output logic             sig_serial_out,
  output logic             sig_serial_valid
);

  localparam int BIT_W = $clog2(SIG_W + 1);

  typedef enum logic [1:0] {IDLE, COMPACT, DONE, UNLOAD} state_t;

  state_t           state, state_nxt;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] shadow_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] count_q;
  logic [BIT_W-1:0] bit_cnt_q;

  logic [SIG_W-1:0] data_ext;
  logic [SIG_W-1:0] sig_next;
  logic [CNT_W-1:0] beat_cnt_inc;
  logic             start_ok;
  logic             unload_ok;

  assign data_ext     = SIG_W'(data_in);
  assign sig_next     = {sig_q[SIG_W-2:0], 1'b0}
                      ^ (sig_q[SIG_W-1] ? POLY : '0)
                      ^ data_ext;
  // The counter stops at the latched count, so this increment never wraps,
  // even for a count of all ones.
  assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

  assign start_ok  = start && (state == IDLE || state == DONE);
  // start has priority over unload in DONE
  assign unload_ok = unload && (state == DONE) && !start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start_ok) begin
          state_nxt = (pattern_count == '0) ? DONE : COMPACT;
        end else if (unload_ok) begin
          state_nxt = UNLOAD;
        end
      end
      COMPACT: begin
        if (data_valid && beat_cnt_inc == count_q) begin
          state_nxt = DONE;
        end
      end
      UNLOAD: begin
        if (bit_cnt_q == BIT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_q      <= SEED;
      shadow_q   <= '0;
      beat_cnt_q <= '0;
      count_q    <= '0;
      bit_cnt_q  <= '0;
    end else begin
      if (start_ok) begin
        sig_q      <= SEED;
        beat_cnt_q <= '0;
        count_q    <= pattern_count;
      end else if (unload_ok) begin
        shadow_q  <= sig_q;
        bit_cnt_q <= BIT_W'(SIG_W);
      end else if (state == COMPACT && data_valid) begin
        sig_q      <= sig_next;
        beat_cnt_q <= beat_cnt_inc;
      end else if (state == UNLOAD) begin
        shadow_q  <= {shadow_q[SIG_W-2:0], 1'b0};
        bit_cnt_q <= bit_cnt_q - BIT_W'(1);
      end
    end
  end

  assign signature        = sig_q;
  assign busy             = (state == COMPACT) || (state == UNLOAD);
  assign done             = (state == DONE);
  assign pass_nfail       = ((state == DONE) || (state == UNLOAD)) && (sig_q == GOLDEN);
  assign sig_serial_valid = (state == UNLOAD);
  assign sig_serial_out   = (state == UNLOAD) && shadow_q[SIG_W-1];

endmodule

// File: tb/tb_misr_compactor.sv
module tb_misr_compactor;

  logic        clock;
  logic        reset;
  logic        start;
  logic        data_valid;
  logic [9:0]  data_in;
  logic [15:0] pattern_count;
  logic        unload;
  logic [15:0] signature;
  logic        busy;
  logic        done;
  logic        pass_nfail;
  logic        sig_serial_out;
  logic        sig_serial_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] sig;
    logic        pass;
  } done_exp_t;

  done_exp_t exp_done[$];
  logic      exp_bits[$];

  misr_compactor #(
    .SIG_W (16),
    .IN_W  (10),
    .POLY  (16'h1021),
    .SEED  (16'h0000),
    .GOLDEN(16'h0000),
    .CNT_W (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .data_valid      (data_valid),
    .data_in         (data_in),
    .pattern_count   (pattern_count),
    .unload          (unload),
    .signature       (signature),
    .busy            (busy),
    .done            (done),
    .pass_nfail      (pass_nfail),
    .sig_serial_out  (sig_serial_out),
    .sig_serial_valid(sig_serial_valid)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input logic [15:0] cnt);
    start = 1;
    pattern_count = cnt;
    tick();
    start = 0;
  endtask

  task automatic beat(input logic [9:0] d);
    data_valid = 1;
    data_in = d;
    tick();
    data_valid = 0;
    data_in = '0;
  endtask

  task automatic push_done(input logic [15:0] s, input logic p);
    done_exp_t e;
    e.sig = s;
    e.pass = p;
    exp_done.push_back(e);
  endtask

  task automatic push_bits(input logic [15:0] v);
    logic [15:0] w;
    w = v;
    for (int i = 15; i >= 0; i--) exp_bits.push_back(w[i]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk(name, done, 1'b1);
  endtask

  // Monitor: serial bits and completed runs are checked against the scoreboard.
  initial begin
    logic      done_prev;
    logic      b;
    done_exp_t e;
    done_prev = 0;
    forever begin
      @(negedge clock);
      if (sig_serial_valid) begin
        if (exp_bits.size() == 0) begin
          total++;
          bad++;
          $display("FAIL serial_extra: got bit %b expected none", sig_serial_out);
        end else begin
          b = exp_bits.pop_front();
          chk("serial_bit", sig_serial_out, b);
        end
      end
      if (done && !done_prev) begin
        if (exp_done.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_extra: got sig %h expected no completion", signature);
        end else begin
          e = exp_done.pop_front();
          chk("done_sig", signature, e.sig);
          chk("done_pass", pass_nfail, e.pass);
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; start = 0; data_valid = 0; data_in = '0;
    pattern_count = '0; unload = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_sig", signature, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass_nfail, 1'b0);
    chk("rst_sout", sig_serial_out, 1'b0);
    chk("rst_svalid", sig_serial_valid, 1'b0);
    reset = 0;
    tick();

    // zero-length run
    push_done(16'h0000, 1'b1);
    start_run(16'd0);
    chk("cnt0_done", done, 1'b1);
    chk("cnt0_busy", busy, 1'b0);
    chk("cnt0_pass", pass_nfail, 1'b1);
    tick();

    // two beats
    push_done(16'h0002, 1'b0);
    start_run(16'd2);
    chk("run2_busy", busy, 1'b1);
    chk("run2_seed", signature, 16'h0000);
    beat(10'h001);
    chk("run2_b1", signature, 16'h0001);
    chk("run2_b1_done", done, 1'b0);
    beat(10'h000);
    chk("run2_b2", signature, 16'h0002);
    chk("run2_done", done, 1'b1);
    tick();

    // feedback: 16 beats bring the seed bit to the MSB, the 17th folds POLY in
    push_done(16'h1021, 1'b0);
    start_run(16'd17);
    beat(10'h001);
    repeat (15) beat(10'h000);
    chk("poly_pre", signature, 16'h8000);
    chk("poly_pre_done", done, 1'b0);
    beat(10'h000);
    chk("poly_fb", signature, 16'h1021);
    chk("poly_done", done, 1'b1);
    tick();

    // gaps in data_valid
    push_done(16'h0007, 1'b0);
    start_run(16'd2);
    beat(10'h003);
    data_in = 10'h3FF;
    tick();
    tick();
    data_in = '0;
    chk("gap_hold", signature, 16'h0003);
    chk("gap_done", done, 1'b0);
    chk("gap_busy", busy, 1'b1);
    beat(10'h001);
    chk("gap_sig", signature, 16'h0007);
    chk("gap_fin", done, 1'b1);
    tick();

    // build A5C3 without feedback, then unload it
    push_done(16'hA5C3, 1'b0);
    start_run(16'd7);
    beat(10'h297);
    repeat (5) beat(10'h000);
    beat(10'h003);
    chk("a5c3_sig", signature, 16'hA5C3);
    chk("a5c3_done", done, 1'b1);
    tick();

    push_bits(16'hA5C3);
    push_done(16'hA5C3, 1'b0);
    unload = 1;
    tick();
    unload = 0;
    chk("unl_busy", busy, 1'b1);
    chk("unl_done", done, 1'b0);
    chk("unl_valid", sig_serial_valid, 1'b1);
    start = 1;
    pattern_count = 16'd3;
    repeat (4) tick();
    chk("unl_start_ign", busy, 1'b1);
    chk("unl_sig_hold", signature, 16'hA5C3);
    start = 0;
    wait_done("unl_finish");
    chk("unl_sig_after", signature, 16'hA5C3);
    chk("unl_bits_left", exp_bits.size(), 0);
    tick();

    // start and unload together in DONE: start wins
    start = 1;
    unload = 1;
    pattern_count = 16'd0;
    tick();
    start = 0;
    unload = 0;
    chk("both_done", done, 1'b1);
    chk("both_svalid", sig_serial_valid, 1'b0);
    chk("both_sig", signature, 16'h0000);
    tick();

    // reset mid-COMPACT
    start_run(16'd5);
    beat(10'h003);
    beat(10'h004);
    #2 reset = 1;
    #1;
    chk("rstc_sig", signature, 16'h0000);
    chk("rstc_busy", busy, 1'b0);
    chk("rstc_done", done, 1'b0);
    #2 reset = 0;
    tick();
    push_done(16'h0002, 1'b0);
    start_run(16'd2);
    beat(10'h001);
    beat(10'h000);
    chk("rstc_rerun", signature, 16'h0002);
    tick();

    // reset mid-UNLOAD
    push_bits(16'h0002);
    unload = 1;
    tick();
    unload = 0;
    repeat (3) tick();
    #2 reset = 1;
    #1;
    chk("rstu_svalid", sig_serial_valid, 1'b0);
    chk("rstu_sout", sig_serial_out, 1'b0);
    chk("rstu_busy", busy, 1'b0);
    chk("rstu_done", done, 1'b0);
    chk("rstu_pass", pass_nfail, 1'b0);
    chk("rstu_bits_seen", exp_bits.size(), 13);
    exp_bits.delete();
    #2 reset = 0;
    tick();

    push_done(16'h03FF, 1'b0);
    start_run(16'd1);
    chk("post_seed", signature, 16'h0000);
    chk("post_busy", busy, 1'b1);
    beat(10'h3FF);
    chk("post_sig", signature, 16'h03FF);
    chk("post_done", done, 1'b1);

    repeat (3) tick();
    chk("sb_done_empty", exp_done.size(), 0);
    chk("sb_bits_empty", exp_bits.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
